// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - FSM state encodings and counter sizing for serial_adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit so the counter can step past WIDTH-1 in the cycle after the last shift.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder with done pulse; SERIAL_ADDER_OVF_EN adds signed overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    count;
    logic             carry_q;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
    assign res_next = WIDTH'({fa_sum, res_sh} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            count   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_next;
                    carry_q <= fa_cout;
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        sum   <= res_next;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry_q ^ fa_cout;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1); checks ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf1;
`endif

    int total;
    int bad;

    // {cout,sum} and signed overflow for index {a,b,cin}
    logic [1:0] fa_tbl  [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic       ovf_tbl [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with dut8 in IDLE/DONE; returns in the first busy cycle.
    task automatic do_start8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        cin8   = cv;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'h00;
        b8     = 8'h00;
        cin8   = 1'b0;
    endtask

    // Cycles counted from the first busy cycle (=1); returns in the done cycle or at the bound.
    task automatic wait_done8(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = (busy8 === 1'b1) ? 1 : 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy8 === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done8); end
        total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout8); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf8); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bc;
        do_start8(8'h5A, 8'h3C, 1'b0);
        wait_done8(lat, bc);
        total++; if (lat != 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
        total++; if (bc != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", bc); end
        total++; if (sum8 !== 8'h96) begin bad++; $display("FAIL basic_sum got=%h want=96", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", cout8); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf8 !== 1'b1) begin bad++; $display("FAIL basic_ovf got=%b want=1", ovf8); end
`endif
        @(negedge clk);
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done8); end
    endtask

    task automatic test_carry;
        int lat, bc;
        do_start8(8'hFF, 8'h01, 1'b0);
        total++; if (sum8 !== 8'h96) begin bad++; $display("FAIL carry_hold_sum got=%h want=96", sum8); end
        wait_done8(lat, bc);
        total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL carry_ff_sum got=%h want=00", sum8); end
        total++; if (cout8 !== 1'b1) begin bad++; $display("FAIL carry_ff_cout got=%b want=1", cout8); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL carry_ff_ovf got=%b want=0", ovf8); end
`endif
        @(negedge clk);
        do_start8(8'h7F, 8'h01, 1'b0);
        total++; if (cout8 !== 1'b1) begin bad++; $display("FAIL carry_hold_cout got=%b want=1", cout8); end
        wait_done8(lat, bc);
        total++; if (sum8 !== 8'h80) begin bad++; $display("FAIL carry_7f_sum got=%h want=80", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL carry_7f_cout got=%b want=0", cout8); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf8 !== 1'b1) begin bad++; $display("FAIL carry_7f_ovf got=%b want=1", ovf8); end
`endif
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat, bc, dones;
        do_start8(8'h01, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'h00;
        wait_done8(lat, bc);
        total++; if (lat >= 40) begin bad++; $display("FAIL ignore_timeout got=%0d want<40", lat); end
        total++; if (sum8 !== 8'h02) begin bad++; $display("FAIL ignore_sum got=%h want=02", sum8); end
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL ignore_second_done got=%0d want=0", dones); end
    endtask

    task automatic test_reset_mid;
        int lat, bc, dones;
        do_start8(8'h03, 8'h04, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done8); end
        total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL rstmid_sum got=%h want=00", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL rstmid_cout got=%b want=0", cout8); end
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", dones); end
        do_start8(8'h12, 8'h34, 1'b0);
        wait_done8(lat, bc);
        total++; if (lat != 9) begin bad++; $display("FAIL rstmid_fresh_latency got=%0d want=9", lat); end
        total++; if (sum8 !== 8'h46) begin bad++; $display("FAIL rstmid_fresh_sum got=%h want=46", sum8); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        do_start8(8'h10, 8'h20, 1'b0);
        wait_done8(lat, bc);
        total++; if (sum8 !== 8'h30) begin bad++; $display("FAIL b2b_first_sum got=%h want=30", sum8); end
        do_start8(8'hAA, 8'h55, 1'b1);
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL b2b_done_clear got=%b want=0", done8); end
        repeat (3) @(negedge clk);
        total++; if (sum8 !== 8'h30) begin bad++; $display("FAIL b2b_hold_sum got=%h want=30", sum8); end
        wait_done8(lat, bc);
        total++; if (lat != 6) begin bad++; $display("FAIL b2b_latency got=%0d want=6", lat); end
        total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL b2b_sum got=%h want=00", sum8); end
        total++; if (cout8 !== 1'b1) begin bad++; $display("FAIL b2b_cout got=%b want=1", cout8); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b want=0", ovf8); end
`endif
        @(negedge clk);
    endtask

    task automatic test_width1;
        int lat;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v      = 3'(i);
            start1 = 1'b1;
            a1     = v[2];
            b1     = v[1];
            cin1   = v[0];
            @(negedge clk);
            start1 = 1'b0;
            total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL w1_busy[%0d] got=%b want=1", i, busy1); end
            lat = 1;
            while (done1 !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            total++; if (lat != 2) begin bad++; $display("FAIL w1_latency[%0d] got=%0d want=2", i, lat); end
            total++; if ({cout1, sum1} !== fa_tbl[i]) begin bad++; $display("FAIL w1_result[%0d] got=%b want=%b", i, {cout1, sum1}, fa_tbl[i]); end
`ifdef SERIAL_ADDER_OVF_EN
            total++; if (ovf1 !== ovf_tbl[i]) begin bad++; $display("FAIL w1_ovf[%0d] got=%b want=%b", i, ovf1, ovf_tbl[i]); end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
